// File: rtl/fc_train_pkg.sv
// ============================================================================
//  Module      : fc_train_pkg
//  Description : Shared types and constants for the FC training sequencer.
//                Holds the sequencer state encoding, the FC memory
//                bank-select codes and small helpers that decode them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_train_pkg;

    // Sequencer states. Explicit 4-bit encoding keeps ERR distinct from
    // the eight run-time states.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_FC1  = 4'd1,
        ST_FC2  = 4'd2,
        ST_OUT  = 4'd3,
        ST_BP   = 4'd4,
        ST_GAP  = 4'd5,
        ST_UPD  = 4'd6,
        ST_FIN  = 4'd7,
        ST_ERR  = 4'd8
    } fc_state_t;

    // Bank select {fc1_com_end, fc2_com_end}. 2'b01 is never driven.
    localparam logic [1:0] BANK_RAM0 = 2'b00;
    localparam logic [1:0] BANK_RAM1 = 2'b10;
    localparam logic [1:0] BANK_RAM2 = 2'b11;

    // Bank select that belongs to a state.
    function automatic logic [1:0] bank_of(input fc_state_t s);
        logic [1:0] b;
        case (s)
            ST_FC2:        b = BANK_RAM1;
            ST_OUT, ST_BP: b = BANK_RAM2;
            default:       b = BANK_RAM0;
        endcase
        return b;
    endfunction

    // States that wait on an external handshake and are therefore
    // covered by the watchdog.
    function automatic logic counts_wait(input fc_state_t s);
        return (s == ST_FC1) || (s == ST_FC2) || (s == ST_OUT) ||
               (s == ST_BP)  || (s == ST_UPD);
    endfunction

endpackage : fc_train_pkg

`default_nettype wire

// File: rtl/fc_seq_watchdog.sv
// ============================================================================
//  Module      : fc_seq_watchdog
//  Description : Per-state wait-cycle counter for the FC training sequencer.
//                Clears whenever the sequencer changes state, counts while
//                the sequencer sits in a handshake wait state, and flags a
//                timeout once the count reaches TIMEOUT_CYCLES (saturating).
//                Only built when FC_TRAIN_SEQ_TIMEOUT_EN is defined.
//  Ports       : clk        - clock
//                rst        - asynchronous active-high reset
//                i_clear    - state transition this cycle, restart count
//                i_count_en - current state is a watched wait state
//                o_timeout  - count has reached TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef FC_TRAIN_SEQ_TIMEOUT_EN
module fc_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_timeout
);

    localparam int              c_CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT_CYCLES);

    logic [c_CW-1:0] r_count;

    // Counter is zero in the first cycle of every state, so a value of
    // TIMEOUT_CYCLES means that many full cycles have been spent waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign o_timeout = (r_count == c_LIMIT);

endmodule : fc_seq_watchdog
`endif

`default_nettype wire

// File: rtl/fc_train_seq.sv
// ============================================================================
//  Module      : fc_train_seq
//  Description : Sequences one FC training run over a mini-batch. For each
//                sample it starts FC1, FC2 and the output/label stage, then
//                requests backprop from the FC memory; after BATCH_SIZE
//                samples it requests the weight update. Drives the memory
//                bank select {fc1_com_end, fc2_com_end}. All outputs are
//                registered (decoded from the next state).
//  Option      : `define FC_TRAIN_SEQ_TIMEOUT_EN builds a per-state
//                watchdog (fc_seq_watchdog) that forces ERR after
//                TIMEOUT_CYCLES in a wait state. Undefined: err tied 0.
//  Ports       : clk, reset (async, active high)
//                start                          - run request (IDLE/ERR only)
//                fc1_done/fc2_done/out_done     - stage completion pulses
//                fc_bck_prop_end/fc_batch_end   - memory status levels
//                fc1_com_end/fc2_com_end        - bank select MSB/LSB
//                bck_prop_start/batch_end       - memory request levels
//                fc1_go/fc2_go/out_go           - stage start pulses
//                sample_idx                     - current sample index
//                busy/train_done/err            - status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_train_seq #(
    parameter int BATCH_SIZE     = 32,
    parameter int SW             = $clog2(BATCH_SIZE),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          fc1_done,
    input  logic          fc2_done,
    input  logic          out_done,
    input  logic          fc_bck_prop_end,
    input  logic          fc_batch_end,
    output logic          fc1_com_end,
    output logic          fc2_com_end,
    output logic          bck_prop_start,
    output logic          batch_end,
    output logic          fc1_go,
    output logic          fc2_go,
    output logic          out_go,
    output logic [SW-1:0] sample_idx,
    output logic          busy,
    output logic          train_done,
    output logic          err
);

    import fc_train_pkg::*;

    localparam logic [SW-1:0] c_LAST_IDX = SW'(BATCH_SIZE - 1);

    if ((BATCH_SIZE < 2) || (BATCH_SIZE > 256) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("fc_train_seq: BATCH_SIZE must be 2..256 and TIMEOUT_CYCLES >= 1");
    end

    fc_state_t     r_state;
    fc_state_t     w_next;
    logic [SW-1:0] w_idx_next;

    logic [1:0]    r_bank;
    logic          r_bps;
    logic          r_be;
    logic          r_fc1_go;
    logic          r_fc2_go;
    logic          r_out_go;
    logic [SW-1:0] r_idx;
    logic          r_busy;
    logic          r_td;

`ifdef FC_TRAIN_SEQ_TIMEOUT_EN
    logic w_entry;
    logic w_count_en;
    logic w_timeout;
    logic r_err;

    assign w_entry    = (w_next != r_state);
    assign w_count_en = counts_wait(r_state);

    fc_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_entry),
        .i_count_en (w_count_en),
        .o_timeout  (w_timeout)
    );
`endif

    // ------------------------------------------------------------------
    // Next-state and next-index logic. Each state only looks at its own
    // handshake input, so stray or early done pulses fall through.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)           w_next = ST_FC1;
            ST_FC1:  if (fc1_done)        w_next = ST_FC2;
            ST_FC2:  if (fc2_done)        w_next = ST_OUT;
            ST_OUT:  if (out_done)        w_next = ST_BP;
            ST_BP:   if (fc_bck_prop_end) w_next = ST_GAP;
            // One cycle with bck_prop_start low lets the memory re-arm.
            ST_GAP:  w_next = (r_idx == c_LAST_IDX) ? ST_UPD : ST_FC1;
            ST_UPD:  if (fc_batch_end)    w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            ST_ERR:  if (start)           w_next = ST_FC1;
            default: w_next = ST_IDLE;
        endcase
`ifdef FC_TRAIN_SEQ_TIMEOUT_EN
        if (w_timeout && w_count_en) begin
            w_next = ST_ERR;
        end
`endif
    end

    always_comb begin
        w_idx_next = r_idx;
        if ((r_state == ST_GAP) && (w_next == ST_FC1)) begin
            w_idx_next = r_idx + SW'(1);
        end else if ((r_state == ST_FIN) ||
                     (((r_state == ST_IDLE) || (r_state == ST_ERR)) && (w_next == ST_FC1))) begin
            w_idx_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the state being
    // entered, so the bank select only moves on a transition and each go
    // pulse lands in the first cycle of its state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bank   <= BANK_RAM0;
            r_bps    <= 1'b0;
            r_be     <= 1'b0;
            r_fc1_go <= 1'b0;
            r_fc2_go <= 1'b0;
            r_out_go <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_td     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_bank   <= bank_of(w_next);
            r_bps    <= (w_next == ST_BP);
            r_be     <= (w_next == ST_UPD);
            r_fc1_go <= (w_next == ST_FC1) && (r_state != ST_FC1);
            r_fc2_go <= (w_next == ST_FC2) && (r_state != ST_FC2);
            r_out_go <= (w_next == ST_OUT) && (r_state != ST_OUT);
            r_idx    <= w_idx_next;
            r_busy   <= (w_next != ST_IDLE) && (w_next != ST_ERR);
            r_td     <= (w_next == ST_FIN);
        end
    end

`ifdef FC_TRAIN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_next == ST_ERR);
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign fc1_com_end    = r_bank[1];
    assign fc2_com_end    = r_bank[0];
    assign bck_prop_start = r_bps;
    assign batch_end      = r_be;
    assign fc1_go         = r_fc1_go;
    assign fc2_go         = r_fc2_go;
    assign out_go         = r_out_go;
    assign sample_idx     = r_idx;
    assign busy           = r_busy;
    assign train_done     = r_td;

endmodule : fc_train_seq

`default_nettype wire

// File: tb/tb_fc_train_seq.sv
// ============================================================================
//  Module      : tb_fc_train_seq
//  Description : Self-checking bench for fc_train_seq. Two instances
//                (BATCH_SIZE=2 and 32) share one stimulus set routed by
//                'sel'. Expected stage events are queued when a run starts
//                and popped as the selected instance produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_train_seq;

    localparam int EV_FC1  = 1;
    localparam int EV_FC2  = 2;
    localparam int EV_OUT  = 3;
    localparam int EV_BP   = 4;
    localparam int EV_GAP  = 5;
    localparam int EV_UPD  = 6;
    localparam int EV_DONE = 7;

    typedef struct {
        int         kind;
        logic [1:0] bank;
        int         idx;   // -1: index not checked
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic in_start, in_fc1, in_fc2, in_out, in_bpe, in_be;

    always #5 clk = ~clk;

    // Instance A: BATCH_SIZE=2
    logic       a_start, a_fc1d, a_fc2d, a_outd, a_bpe, a_bed;
    logic       a_fc1c, a_fc2c, a_bps, a_be, a_fc1_go, a_fc2_go, a_out_go;
    logic [0:0] a_idx;
    logic       a_busy, a_td, a_err;
    // Instance B: BATCH_SIZE=32
    logic       b_start, b_fc1d, b_fc2d, b_outd, b_bpe, b_bed;
    logic       b_fc1c, b_fc2c, b_bps, b_be, b_fc1_go, b_fc2_go, b_out_go;
    logic [4:0] b_idx;
    logic       b_busy, b_td, b_err;

    assign a_start = in_start & ~sel;  assign b_start = in_start & sel;
    assign a_fc1d  = in_fc1   & ~sel;  assign b_fc1d  = in_fc1   & sel;
    assign a_fc2d  = in_fc2   & ~sel;  assign b_fc2d  = in_fc2   & sel;
    assign a_outd  = in_out   & ~sel;  assign b_outd  = in_out   & sel;
    assign a_bpe   = in_bpe   & ~sel;  assign b_bpe   = in_bpe   & sel;
    assign a_bed   = in_be    & ~sel;  assign b_bed   = in_be    & sel;

    fc_train_seq #(.BATCH_SIZE(2), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .fc1_done(a_fc1d), .fc2_done(a_fc2d), .out_done(a_outd),
        .fc_bck_prop_end(a_bpe), .fc_batch_end(a_bed),
        .fc1_com_end(a_fc1c), .fc2_com_end(a_fc2c),
        .bck_prop_start(a_bps), .batch_end(a_be),
        .fc1_go(a_fc1_go), .fc2_go(a_fc2_go), .out_go(a_out_go),
        .sample_idx(a_idx), .busy(a_busy), .train_done(a_td), .err(a_err)
    );

    fc_train_seq #(.BATCH_SIZE(32), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .fc1_done(b_fc1d), .fc2_done(b_fc2d), .out_done(b_outd),
        .fc_bck_prop_end(b_bpe), .fc_batch_end(b_bed),
        .fc1_com_end(b_fc1c), .fc2_com_end(b_fc2c),
        .bck_prop_start(b_bps), .batch_end(b_be),
        .fc1_go(b_fc1_go), .fc2_go(b_fc2_go), .out_go(b_out_go),
        .sample_idx(b_idx), .busy(b_busy), .train_done(b_td), .err(b_err)
    );

    // Observed outputs of the selected instance.
    logic [1:0] o_bank;
    logic       o_bps, o_be, o_fc1_go, o_fc2_go, o_out_go, o_busy, o_td;
    logic [7:0] o_idx;
    assign o_bank   = sel ? {b_fc1c, b_fc2c} : {a_fc1c, a_fc2c};
    assign o_bps    = sel ? b_bps    : a_bps;
    assign o_be     = sel ? b_be     : a_be;
    assign o_fc1_go = sel ? b_fc1_go : a_fc1_go;
    assign o_fc2_go = sel ? b_fc2_go : a_fc2_go;
    assign o_out_go = sel ? b_out_go : a_out_go;
    assign o_busy   = sel ? b_busy   : a_busy;
    assign o_td     = sel ? b_td     : a_td;
    assign o_idx    = sel ? 8'(b_idx) : 8'(a_idx);

    function automatic ev_t mk_ev(input int k, input logic [1:0] b, input int i);
        ev_t e;
        e.kind = k; e.bank = b; e.idx = i;
        return e;
    endfunction

    task automatic clear_inputs;
        in_start = 0; in_fc1 = 0; in_fc2 = 0; in_out = 0; in_bpe = 0; in_be = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        logic [11:0] va, vb;
        #3;
        va = {a_fc1c, a_fc2c, a_bps, a_be, a_fc1_go, a_fc2_go, a_out_go, a_idx, a_busy, a_td, a_err, 1'b0};
        vb = {b_fc1c, b_fc2c, b_bps, b_be, b_fc1_go, b_fc2_go, b_out_go, b_busy, b_td, b_err, 2'b00};
        n_cmp++;
        if (va !== 12'h000) begin
            n_bad++; $display("FAIL reset_outputs_a: got %h required 000", va);
        end
        n_cmp++;
        if (vb !== 12'h000 || b_idx !== 5'd0) begin
            n_bad++; $display("FAIL reset_outputs_b: got %h idx %0d required 000 idx 0", vb, b_idx);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Runs one full batch on the selected instance with a reactive
    // datapath/memory model. lat: cycles from go/request to done;
    // hold: cycles fc_bck_prop_end stays high; stray: inject fc2_done in
    // FC1 and fc1_done together with fc_bck_prop_end.
    task automatic run_batch(input string tag, input int n, input int lat,
                             input int hold, input bit stray);
        ev_t e;
        int  cyc, trig, kind, budget, done_cyc, n_bp, n_done, bpe_left;
        int  fc1_at, fc2_at, out_at, bpe_at, be_at, stray_at, stray_chk;
        bit  prev_bps, prev_be, finished;

        sb.delete();
        for (int s = 0; s < n; s++) begin
            sb.push_back(mk_ev(EV_FC1, 2'b00, s));
            sb.push_back(mk_ev(EV_FC2, 2'b10, s));
            sb.push_back(mk_ev(EV_OUT, 2'b11, s));
            sb.push_back(mk_ev(EV_BP,  2'b11, s));
            sb.push_back(mk_ev(EV_GAP, 2'b00, s));
        end
        sb.push_back(mk_ev(EV_UPD,  2'b00, n - 1));
        sb.push_back(mk_ev(EV_DONE, 2'b00, -1));

        fc1_at = -1; fc2_at = -1; out_at = -1; bpe_at = -1; be_at = -1;
        stray_at = -1; stray_chk = -1; done_cyc = -1;
        n_bp = 0; n_done = 0; bpe_left = 0; prev_bps = 0; prev_be = 0;
        finished = 0; budget = 60 * n + 50;

        @(negedge clk);
        in_start = 1'b1;
        cyc = 0; trig = 0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            in_start = 0; in_fc1 = 0; in_fc2 = 0; in_out = 0; in_be = 0;
            if (bpe_left > 0) bpe_left--;
            if (bpe_left == 0) in_bpe = 0;

            if (cyc == stray_chk) begin
                n_cmp++;
                if (o_bank !== 2'b00 || o_fc2_go !== 1'b0 || o_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s stray_fc2_done: bank %b fc2_go %b busy %b, required 00 0 1",
                             tag, o_bank, o_fc2_go, o_busy);
                end
            end

            kind = 0;
            if (o_fc1_go)               kind = EV_FC1;
            else if (o_fc2_go)          kind = EV_FC2;
            else if (o_out_go)          kind = EV_OUT;
            else if (o_bps && !prev_bps) kind = EV_BP;
            else if (!o_bps && prev_bps) kind = EV_GAP;
            else if (o_be && !prev_be)  kind = EV_UPD;
            else if (o_td)              kind = EV_DONE;
            prev_bps = o_bps;
            prev_be  = o_be;

            if (kind != 0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s unexpected_event: got kind %0d at cycle %0d, required none", tag, kind, cyc);
                end else begin
                    e = sb.pop_front();
                    if (kind !== e.kind || o_bank !== e.bank || (e.idx >= 0 && o_idx !== 8'(e.idx))) begin
                        n_bad++;
                        $display("FAIL %s event: got kind %0d bank %b idx %0d, required kind %0d bank %b idx %0d",
                                 tag, kind, o_bank, o_idx, e.kind, e.bank, e.idx);
                    end
                    n_cmp++;
                    if (cyc !== trig + 1) begin
                        n_bad++;
                        $display("FAIL %s latency kind %0d: got cycle %0d, required %0d", tag, kind, cyc, trig + 1);
                    end
                end
                case (kind)
                    EV_FC1: begin
                        fc1_at = cyc + lat;
                        if (stray) begin stray_at = cyc + 1; stray_chk = cyc + 2; end
                    end
                    EV_FC2: fc2_at = cyc + lat;
                    EV_OUT: out_at = cyc + lat;
                    EV_BP:  begin bpe_at = cyc + lat; n_bp++; end
                    EV_GAP: trig = cyc;
                    EV_UPD: begin
                        be_at = cyc + lat;
                        n_cmp++;
                        if (n_bp !== n) begin
                            n_bad++;
                            $display("FAIL %s bp_requests: got %0d, required %0d", tag, n_bp, n);
                        end
                    end
                    EV_DONE: begin n_done++; done_cyc = cyc; end
                    default: ;
                endcase
            end

            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                n_cmp++;
                if (o_idx !== 8'd0 || o_busy !== 1'b0 || o_be !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s idle_after_done: idx %0d busy %b batch_end %b, required 0 0 0",
                             tag, o_idx, o_busy, o_be);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) finished = 1;

            // Datapath / memory model drives its responses for this cycle.
            if (cyc == fc1_at) begin in_fc1 = 1; trig = cyc; end
            if (cyc == fc2_at) begin in_fc2 = 1; trig = cyc; end
            if (cyc == out_at) begin in_out = 1; trig = cyc; end
            if (cyc == bpe_at) begin
                in_bpe = 1; bpe_left = hold; trig = cyc;
                if (stray) in_fc1 = 1;
            end
            if (cyc == be_at) begin in_be = 1; trig = cyc; end
            if (cyc == stray_at) in_fc2 = 1;
        end

        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL %s timeout: got %0d cycles without completion, required completion", tag, cyc);
        end
        n_cmp++;
        if (sb.size() != 0 || n_done !== 1) begin
            n_bad++;
            $display("FAIL %s leftovers: got %0d pending, %0d train_done, required 0 pending, 1 train_done",
                     tag, sb.size(), n_done);
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_in_bp;
        sel = 0;
        @(negedge clk);
        in_start = 1;
        for (int i = 0; i < 200 && !(a_bps && a_idx == 1'b1); i++) begin
            @(negedge clk);
            in_start = 0;
            in_fc1 = a_fc1_go;
            in_fc2 = a_fc2_go;
            in_out = a_out_go;
            in_bpe = a_bps && (a_idx == 1'b0);
        end
        n_cmp++;
        if (!(a_bps === 1'b1 && a_idx === 1'b1)) begin
            n_bad++;
            $display("FAIL reach_bp_sample1: bps %b idx %0d, required 1 1", a_bps, a_idx);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_bps !== 1'b0 || a_busy !== 1'b0 || a_idx !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_in_bp: bps %b busy %b idx %0d, required 0 0 0", a_bps, a_busy, a_idx);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        run_batch("after_reset", 2, 3, 1, 0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout;
        logic exp_err;
        do_reset();
        sel = 0;
        @(negedge clk);
        in_start = 1;
        @(negedge clk);
        in_start = 0;
        n_cmp++;
        if (a_fc1_go !== 1'b1) begin
            n_bad++; $display("FAIL wd_first_go: fc1_go %b, required 1", a_fc1_go);
        end
`ifdef FC_TRAIN_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_err = (k == 17);
            n_cmp++;
            if (a_err !== exp_err) begin
                n_bad++; $display("FAIL wd_err cycle %0d: got %b, required %b", k, a_err, exp_err);
            end
        end
        n_cmp++;
        if ({a_bps, a_be, a_fc1_go, a_fc2_go, a_out_go, a_fc1c, a_fc2c, a_busy, a_td} !== 9'd0) begin
            n_bad++;
            $display("FAIL wd_requests_low: got %b, required 000000000",
                     {a_bps, a_be, a_fc1_go, a_fc2_go, a_out_go, a_fc1c, a_fc2c, a_busy, a_td});
        end
        in_start = 1;
        @(negedge clk);
        in_start = 0;
        n_cmp++;
        if (a_err !== 1'b0 || a_fc1_go !== 1'b1 || a_idx !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_restart: err %b fc1_go %b idx %0d, required 0 1 0", a_err, a_fc1_go, a_idx);
        end
`else
        exp_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (a_err !== exp_err || a_busy !== 1'b1) begin
                n_bad++; $display("FAIL no_wd cycle %0d: err %b busy %b, required 0 1", k, a_err, a_busy);
            end
        end
`endif
        do_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_batch;
        sel = 0;
        run_batch("batch2", 2, 3, 1, 0);
    endtask

    task automatic test_stray_done;
        sel = 0;
        run_batch("stray", 2, 3, 1, 1);
    endtask

    task automatic test_bpe_hold;
        sel = 0;
        run_batch("bpe_hold5", 2, 3, 5, 0);
    endtask

    task automatic test_batch32;
        sel = 1;
        run_batch("batch32", 32, 0, 1, 0);
        sel = 0;
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        clear_inputs();
        test_reset();
        test_full_batch();
        test_stray_done();
        test_bpe_hold();
        test_reset_in_bp();
        test_timeout();
        test_batch32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fc_train_seq

`default_nettype wire
